mkio_word_tx: RTL and testbench
===============================

Name: mkio_word_tx

Overview:
- MIL-STD-1553B Manchester II word transmitter for the mkio remote terminal; drives the DO1x/DO0x transceiver pins of one channel.
- Takes 16-bit words plus a sync-type flag over a valid/ready handshake.
- Generates sync, Manchester-encodes data, appends odd parity, and serialises at 1 Mbit/s from the 32 MHz system clock.
- A one-word holding register lets consecutive words go out back-to-back with no gap (status word followed by data words).

Parameters:
- CLK_PER_HALFBIT, 16, clk cycles per Manchester half-bit (500 ns at 32 MHz); must be >= 2.
- MAX_WORDS, 33, maximum contiguous words per burst before the fail-safe abort.

Ports:
- clk  input  1  system clock, 32 MHz.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  16  word to send, MSB transmitted first.
- tx_sync  input  1  1 = command/status sync (half-bits 111000); 0 = data sync (000111).
- tx_valid  input  1  word offered.
- tx_ready  output  1  holding register can accept a word.
- tx_inhibit  input  1  transmitter inhibit; also clears tx_fault.
- DO1  output  1  positive bus drive.
- DO0  output  1  negative bus drive.
- tx_active  output  1  transceiver enable; high while a word is on the bus.
- word_done  output  1  one-cycle pulse at the end of each transmitted word.
- tx_fault  output  1  sticky fail-safe flag.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset). All outputs are registered.
- Reset values: DO1=0, DO0=0, tx_active=0, word_done=0, tx_fault=0, tx_ready=0. State=IDLE, holding register empty, all counters 0. tx_ready rises on the first clk edge after reset deasserts.
- tx_ready = holding register empty AND tx_inhibit=0 AND tx_fault=0.
- Accept: a word is accepted on a clk edge where tx_valid=1 and tx_ready=1. tx_data and tx_sync are latched into the holding register.
- Frame: 40 half-bits, sent MSB first:
  - 6 sync half-bits;
  - for each data bit, MSB to LSB: {d, ~d};
  - parity pair {p, ~p}, where p = 1 XOR (xor-reduce of tx_data), giving odd parity over data+p.
  - Each half-bit lasts CLK_PER_HALFBIT cycles. A word occupies exactly 40*CLK_PER_HALFBIT cycles (640 at default).
- While a word is on the bus: DO1 = current half-bit, DO0 = its complement, tx_active=1.
- States:
  - IDLE: DO1=DO0=0, tx_active=0. If the holding register is full on an edge, that edge loads the frame and enters SHIFT. First half-bit is visible the cycle after acceptance (latency 1 clk).
  - SHIFT: half-bit counter 0..39, divider 0..CLK_PER_HALFBIT-1. On the final edge of half-bit 39, word_done pulses for one cycle, then:
    - if the holding register is full, or a word is accepted on that same edge (bypass), the next frame loads on that edge with zero gap;
    - otherwise go to IDLE and DO1=DO0=0 from the next cycle.
- Burst counter: counts words loaded since the last IDLE and resets in IDLE. Loading word MAX_WORDS+1 is refused: tx_fault=1, holding register cleared, IDLE, outputs 0/0. No word_done is generated for the refused word.
- tx_fault clears only on reset or a cycle with tx_inhibit=1.
- tx_inhibit=1, any state, takes effect on the next edge:
  - DO1=DO0=0 and tx_active=0;
  - current word and held word are discarded;
  - state goes to IDLE, no word_done.
  - After inhibit falls, tx_ready returns on the next edge.
- Reset mid-word: outputs go to 0/0 immediately (asynchronous); the word is lost.
- tx_data/tx_sync changes while not accepted: ignored.

Test Plan:
- Command word: tx_sync=1, tx_data=16'h0867 (addr 1, T/R 0, subaddr 3, count 7). Expect:
  - half-bits 111000, then 01 01 01 01 10 01 01 01 01 10 10 01 01 10 10 10, then parity 10;
  - DO0 = ~DO1 throughout; 640 cycles; word_done once; then idle at 0/0.
- Data word 16'h0000 with tx_sync=0. Expect 000111, then 16×"01", then parity 10 (p=1).
- Data word 16'h0001. Expect parity pair 01 (p=0).
- Contiguous burst: 7 data words (16'h1234 … 16'h7777), each offered as soon as tx_ready rises. Expect:
  - tx_active continuously high for 7×640 cycles;
  - no idle cycle between words; 7 word_done pulses spaced 640 cycles apart.
- Bypass edge: second word presented with tx_valid asserted only on the final edge of word 1. Expect word 2 to start with no gap.
- Fail-safe with MAX_WORDS=2 and 3 words queued. Expect:
  - 2 words sent, then outputs 0/0 and tx_fault=1, tx_ready=0;
  - a 1-cycle tx_inhibit pulse clears the fault and tx_ready returns.
- Inhibit mid-word: tx_inhibit=1 at half-bit 20. Expect on the next edge: DO1=DO0=0, tx_active=0, no word_done, held word dropped. Also assert reset low mid-word: outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/mkio_word_tx.sv
// MIL-STD-1553B Manchester II word transmitter: sync, 16 data bits and odd parity at 1 Mbit/s.
// A one-word holding register gives gap-free bursts; over-long bursts trip a sticky fault.
module mkio_word_tx #(
    parameter int unsigned CLK_PER_HALFBIT = 16,
    parameter int unsigned MAX_WORDS       = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] tx_data,
    input  logic        tx_sync,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        tx_inhibit,
    output logic        DO1,
    output logic        DO0,
    output logic        tx_active,
    output logic        word_done,
    output logic        tx_fault
);
    localparam int unsigned DivW   = $clog2(CLK_PER_HALFBIT);
    localparam int unsigned BurstW = $clog2(MAX_WORDS + 1);
    localparam logic [DivW-1:0]   DivLast  = DivW'(CLK_PER_HALFBIT - 1);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_WORDS);
    localparam logic [5:0]        HbLast   = 6'd39;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [39:0]       frame_q, frame_d;
    logic [5:0]        hb_q, hb_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic [15:0]       hold_data_q, hold_data_d;
    logic              hold_sync_q, hold_sync_d;
    logic              hold_full_q, hold_full_d;
    logic              fault_q, fault_d;
    logic              do1_q, do1_d;
    logic              do0_q, do0_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic              accept;
    logic              load;
    logic [15:0]       load_data;
    logic              load_sync;

    // Frame is held MSB-first: bit 39 is the half-bit currently on the bus.
    function automatic logic [39:0] build_frame(input logic [15:0] d, input logic s);
        logic [31:0] man;
        for (int i = 0; i < 16; i++) begin
            man[2*i +: 2] = {d[i], ~d[i]};
        end
        return {(s ? 6'b111000 : 6'b000111), man, ~^d, ^d};
    endfunction

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        hb_d        = hb_q;
        div_d       = div_q;
        burst_d     = burst_q;
        hold_data_d = hold_data_q;
        hold_sync_d = hold_sync_q;
        hold_full_d = hold_full_q;
        fault_d     = fault_q;
        done_d      = 1'b0;
        load        = 1'b0;
        load_data   = hold_data_q;
        load_sync   = hold_sync_q;
        accept      = tx_valid & ready_q;

        if (tx_inhibit) begin
            state_d     = StIdle;
            hold_full_d = 1'b0;
            fault_d     = 1'b0;
            burst_d     = '0;
        end else begin
            // ready_q implies the holding register is empty, so accepting never overwrites.
            if (accept) begin
                hold_data_d = tx_data;
                hold_sync_d = tx_sync;
                hold_full_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    burst_d = '0;
                    if (hold_full_q) begin
                        load = 1'b1;
                    end
                end
                StShift: begin
                    if (div_q != DivLast) begin
                        div_d = div_q + 1'b1;
                    end else if (hb_q != HbLast) begin
                        div_d   = '0;
                        hb_d    = hb_q + 6'd1;
                        frame_d = {frame_q[38:0], 1'b0};
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else if (accept) begin
                            load      = 1'b1;
                            load_data = tx_data;
                            load_sync = tx_sync;
                        end
                    end
                end
            endcase
            if (load) begin
                hold_full_d = 1'b0;
                if (burst_q == BurstMax) begin
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StShift;
                    frame_d = build_frame(load_data, load_sync);
                    hb_d    = '0;
                    div_d   = '0;
                    burst_d = burst_q + 1'b1;
                end
            end
        end

        active_d = (state_d == StShift);
        do1_d    = active_d & frame_d[39];
        do0_d    = active_d & ~frame_d[39];
        ready_d  = ~hold_full_d & ~tx_inhibit & ~fault_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            frame_q     <= '0;
            hb_q        <= '0;
            div_q       <= '0;
            burst_q     <= '0;
            hold_data_q <= '0;
            hold_sync_q <= 1'b0;
            hold_full_q <= 1'b0;
            fault_q     <= 1'b0;
            do1_q       <= 1'b0;
            do0_q       <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            hb_q        <= hb_d;
            div_q       <= div_d;
            burst_q     <= burst_d;
            hold_data_q <= hold_data_d;
            hold_sync_q <= hold_sync_d;
            hold_full_q <= hold_full_d;
            fault_q     <= fault_d;
            do1_q       <= do1_d;
            do0_q       <= do0_d;
            active_q    <= active_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign DO1       = do1_q;
    assign DO0       = do0_q;
    assign tx_active = active_q;
    assign word_done = done_q;
    assign tx_fault  = fault_q;
    assign tx_ready  = ready_q;

endmodule

// File: tb/tb_mkio_word_tx.sv
// Bench for mkio_word_tx: traces the bus every cycle and checks frames against a half-bit model,
// plus burst, bypass, fail-safe, inhibit and asynchronous-reset sequences.
module tb_mkio_word_tx;
    localparam int Cph     = 16;
    localparam int WordCyc = 40 * Cph;
    localparam int Cph2    = 2;
    localparam int Word2   = 40 * Cph2;
    localparam int TrLen   = 32768;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tx_data;
    logic        tx_sync, tx_valid, tx_inhibit;
    logic        tx_ready, DO1, DO0, tx_active, word_done, tx_fault;

    logic [15:0] tx_data2;
    logic        tx_sync2, tx_valid2, tx_inhibit2;
    logic        tx_ready2, DO1_2, DO0_2, tx_active2, word_done2, tx_fault2;

    mkio_word_tx dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_sync(tx_sync), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_inhibit(tx_inhibit), .DO1(DO1), .DO0(DO0),
        .tx_active(tx_active), .word_done(word_done), .tx_fault(tx_fault)
    );

    mkio_word_tx #(.CLK_PER_HALFBIT(Cph2), .MAX_WORDS(2)) dut_fs (
        .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_sync(tx_sync2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx_inhibit(tx_inhibit2), .DO1(DO1_2), .DO0(DO0_2),
        .tx_active(tx_active2), .word_done(word_done2), .tx_fault(tx_fault2)
    );

    always #5 clk = ~clk;

    // cyc = number of the most recent rising edge; trace slot cyc is the cycle after that edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic tr_do1 [TrLen];
    logic tr_do0 [TrLen];
    logic tr_act [TrLen];
    logic tr_done[TrLen];
    logic tr_rdy [TrLen];
    int   done2_cnt = 0;
    int   act2_cnt  = 0;

    always @(negedge clk) begin
        if (cyc < TrLen) begin
            tr_do1[cyc]  <= DO1;
            tr_do0[cyc]  <= DO0;
            tr_act[cyc]  <= tx_active;
            tr_done[cyc] <= word_done;
            tr_rdy[cyc]  <= tx_ready;
        end
        if (word_done2) done2_cnt <= done2_cnt + 1;
        if (tx_active2) act2_cnt <= act2_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference frame from the word rules: sync, {d,~d} per bit MSB first, odd-parity pair.
    function automatic logic [39:0] model_frame(input logic [15:0] d, input logic s);
        logic [39:0] f;
        logic        p;
        for (int i = 0; i < 6; i++) f[39-i] = s ? (i < 3) : (i >= 3);
        for (int b = 0; b < 16; b++) begin
            f[33-2*b] = d[15-b];
            f[32-2*b] = ~d[15-b];
        end
        p = 1'b1;
        for (int b = 0; b < 16; b++) p = p ^ d[b];
        f[1] = p;
        f[0] = ~p;
        return f;
    endfunction

    task automatic wait_cyc(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic offer(input logic [15:0] d, input logic s, output int acc);
        acc = -1;
        for (int i = 0; i < 2000 && acc < 0; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                tx_data  = d;
                tx_sync  = s;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                tx_data  = 16'($urandom);
                tx_sync  = 1'($urandom);
                acc      = cyc;
            end
        end
        if (acc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL offer_timeout: tx_ready never rose for word %04h", d);
        end
    endtask

    task automatic offer2(input logic [15:0] d, output int acc);
        acc = -1;
        for (int i = 0; i < 500 && acc < 0; i++) begin
            @(negedge clk);
            if (tx_ready2) begin
                tx_data2  = d;
                tx_sync2  = 1'b0;
                tx_valid2 = 1'b1;
                @(negedge clk);
                tx_valid2 = 1'b0;
                acc       = cyc;
            end
        end
        if (acc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fs_offer_timeout: tx_ready never rose for word %04h", d);
        end
    endtask

    // start = trace slot of the word's first half-bit cycle.
    task automatic check_word(input int start, input logic [39:0] exp, input string name);
        logic [39:0] got;
        int          bad;
        logic        eb;
        if (start < 1 || start + WordCyc >= TrLen) return;
        for (int h = 0; h < 40; h++) got[39-h] = tr_do1[start + h*Cph + Cph/2];
        check({name, "_frame"}, got, exp);
        bad = 0;
        for (int k = 0; k < WordCyc; k++) begin
            eb = exp[39 - k/Cph];
            if (tr_do1[start+k] !== eb || tr_do0[start+k] !== ~eb || tr_act[start+k] !== 1'b1 ||
                (k > 0 && tr_done[start+k] !== 1'b0)) bad++;
        end
        check({name, "_bad_cycles"}, bad, 0);
        check({name, "_done"}, tr_done[start+WordCyc], 1);
    endtask

    task automatic check_idle(input int idx, input string name);
        if (idx < 0 || idx >= TrLen) return;
        check(name, {tr_act[idx], tr_do1[idx], tr_do0[idx]}, 0);
    endtask

    typedef struct {
        logic [15:0] data;
        logic        sync;
        logic [39:0] frame;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[4];
        logic [15:0] burst_w[7];
        logic [15:0] d;
        logic        s;
        int          acc, acc0, st, cnt, cnt2;

        tbl[0] = '{16'h0867, 1'b1, 40'b111000_01_01_01_01_10_01_01_01_01_10_10_01_01_10_10_10_10};
        tbl[1] = '{16'h0000, 1'b0, 40'b000111_0101010101010101_0101010101010101_10};
        tbl[2] = '{16'h0001, 1'b0, 40'b000111_0101010101010101_0101010101010110_01};
        tbl[3] = '{16'hFFFF, 1'b1, 40'b111000_1010101010101010_1010101010101010_10};
        burst_w = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h7777};

        reset = 1'b0;
        tx_data = '0; tx_sync = 1'b0; tx_valid = 1'b0; tx_inhibit = 1'b0;
        tx_data2 = '0; tx_sync2 = 1'b0; tx_valid2 = 1'b0; tx_inhibit2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {DO1, DO0, tx_active, word_done, tx_fault, tx_ready}, 0);
        check("reset_outputs_fs", {DO1_2, DO0_2, tx_active2, word_done2, tx_fault2, tx_ready2}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", tx_ready, 1);

        for (int i = 0; i < 4; i++) begin
            offer(tbl[i].data, tbl[i].sync, acc);
            wait_cyc(acc + WordCyc + 3);
            check_word(acc + 1, tbl[i].frame, $sformatf("vec%0d", i));
            check_idle(acc + 1 + WordCyc, $sformatf("vec%0d_idle_after", i));
        end

        for (int r = 0; r < 6; r++) begin
            d = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            offer(d, s, acc);
            wait_cyc(acc + WordCyc + 3);
            check_word(acc + 1, model_frame(d, s), $sformatf("rand%0d_%04h", r, d));
            check_idle(acc + 1 + WordCyc, $sformatf("rand%0d_idle_after", r));
        end

        offer(burst_w[0], 1'b0, acc0);
        for (int i = 1; i < 7; i++) offer(burst_w[i], 1'b0, acc);
        wait_cyc(acc0 + 1 + 7*WordCyc + 3);
        for (int i = 0; i < 7; i++)
            check_word(acc0 + 1 + i*WordCyc, model_frame(burst_w[i], 1'b0), $sformatf("burst%0d", i));
        cnt = 0;
        cnt2 = 0;
        for (int k = acc0 + 1; k < acc0 + 1 + 7*WordCyc; k++) if (tr_act[k] !== 1'b1) cnt++;
        for (int k = acc0 + 1; k <= acc0 + 1 + 7*WordCyc; k++) if (tr_done[k] === 1'b1) cnt2++;
        check("burst_active_gaps", cnt, 0);
        check("burst_done_pulses", cnt2, 7);
        check_idle(acc0 + 1 + 7*WordCyc, "burst_idle_after");

        // Second word offered only in the cycle that ends with word 1's final edge.
        offer(16'hA5C3, 1'b1, acc);
        wait_cyc(acc + WordCyc);
        check("bypass_ready", tx_ready, 1);
        tx_data = 16'h3C5A; tx_sync = 1'b0; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_cyc(acc + 1 + 2*WordCyc + 3);
        check_word(acc + 1, model_frame(16'hA5C3, 1'b1), "bypass_w1");
        check_word(acc + 1 + WordCyc, model_frame(16'h3C5A, 1'b0), "bypass_w2");

        offer(16'h0BAD, 1'b0, acc);
        offer(16'h0F0F, 1'b0, acc0);
        st = acc + 1;
        wait_cyc(st + 20*Cph);
        tx_inhibit = 1'b1;
        @(negedge clk);
        tx_inhibit = 1'b0;
        wait_cyc(st + WordCyc + 100);
        check("inh_active_before", tr_act[st + 20*Cph], 1);
        check_idle(st + 20*Cph + 1, "inh_outputs_off");
        check("inh_ready_low", tr_rdy[st + 20*Cph + 1], 0);
        check("inh_ready_back", tr_rdy[st + 20*Cph + 2], 1);
        cnt = 0;
        cnt2 = 0;
        for (int k = st; k < st + WordCyc + 90; k++) if (tr_done[k] === 1'b1) cnt++;
        for (int k = st + 20*Cph + 1; k < st + WordCyc + 90; k++) if (tr_act[k] !== 1'b0) cnt2++;
        check("inh_no_done", cnt, 0);
        check("inh_held_dropped", cnt2, 0);

        offer2(16'h1111, acc);
        offer2(16'h2222, acc);
        offer2(16'h3333, acc);
        for (int i = 0; i < 500 && !tx_fault2; i++) @(negedge clk);
        @(negedge clk);
        check("fs_fault_set", tx_fault2, 1);
        check("fs_words_sent", done2_cnt, 2);
        check("fs_active_cycles", act2_cnt, 2*Word2);
        check("fs_outputs_off", {DO1_2, DO0_2, tx_active2, tx_ready2}, 0);
        repeat (5) @(negedge clk);
        check("fs_fault_sticky", {tx_fault2, tx_ready2}, 2'b10);
        tx_inhibit2 = 1'b1;
        @(negedge clk);
        tx_inhibit2 = 1'b0;
        check("fs_fault_cleared", {tx_fault2, tx_ready2}, 2'b00);
        @(negedge clk);
        check("fs_ready_back", tx_ready2, 1);
        repeat (20) @(negedge clk);
        check("fs_refused_not_sent", {done2_cnt[7:0], tx_active2}, {8'd2, 1'b0});

        offer(16'hBEEF, 1'b1, acc);
        st = acc + 1;
        wait_cyc(st + 100);
        #2;
        check("rst_mid_active", tx_active, 1);
        reset = 1'b0;
        #1;
        check("rst_async_off", {DO1, DO0, tx_active, word_done}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready_return", tx_ready, 1);
        wait_cyc(st + WordCyc + 20);
        cnt = 0;
        for (int k = st + 101; k < st + WordCyc + 10; k++)
            if (tr_act[k] !== 1'b0 || tr_done[k] !== 1'b0) cnt++;
        check("rst_word_lost", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
